toy_bus_rr_arb_node: RTL and testbench
======================================

# toy_bus_rr_arb_node

Round-robin arbitration node for the toy bus network. It merges N single-beat ToyBus packets (opcode, data, src_id, tgt_id) onto one downstream channel, for example several masters sharing the ITCM port. It is the many-to-one counterpart of the one-to-many decoder nodes. A 2-entry output buffer registers the merged channel, so the path from one node to the next is cut while full throughput is kept.

## Interface
Parameters:
- N_IN, 2: number of requesters, 2..8
- DATA_W, 32: payload data width
- ID_W, 4: src_id / tgt_id width

Ports (clock and reset first; one clock; reset is synchronous and active-high):
- clk  in  1  sole clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_vld  in  N_IN  per-requester valid
- in_rdy  out  N_IN  per-requester ready; at most one bit set
- in_opcode  in  N_IN  opcode; bit i belongs to requester i
- in_data  in  N_IN*DATA_W  data; slice i is [i*DATA_W +: DATA_W]
- in_src_id  in  N_IN*ID_W  source id per requester
- in_tgt_id  in  N_IN*ID_W  target id per requester
- out_vld  out  1  buffer head valid
- out_rdy  in  1  downstream ready
- out_opcode  out  1  head opcode
- out_data  out  DATA_W  head data
- out_src_id  out  ID_W  head src_id
- out_tgt_id  out  ID_W  head tgt_id

## Operation
- State:
  - rr pointer `ptr`: $clog2(N_IN) bits, reset 0.
  - 2-entry payload FIFO: wr_ptr and rd_ptr of 1 bit each, count 0..2. All reset to 0.
- Arbiter, combinational:
  - grant = first i with in_vld[i]=1, scanning ptr, ptr+1, … cyclically mod N_IN.
  - No valid input gives no grant.
- Ready rule: in_rdy[i] = grant[i] && (count < 2).
  - in_rdy may depend on in_vld of every input.
  - Requesters must not make in_vld depend on in_rdy.
- push = |(in_vld & in_rdy). The granted payload is written at wr_ptr, and wr_ptr toggles.
- On push, ptr ← (granted index + 1) mod N_IN. With no push, ptr holds.
  - When count=2, ptr holds even if inputs are valid. No fairness credit is lost.
- pop = out_vld && out_rdy; rd_ptr toggles.
- count update:
  - push only: count+1
  - pop only: count−1
  - push and pop: unchanged
- Outputs:
  - out_vld = (count != 0).
  - out_* = the entry at rd_ptr.
  - out_* hold steady while out_vld=1 and out_rdy=0.
- Ordering: packets leave in exactly the order they were accepted. Payload passes through unmodified.
- Input contract: a requester holding in_vld keeps its payload stable until accepted.

## Timing
- Reset values:
  - in_rdy = 0 while count=2 or no input is valid; otherwise it follows the arbiter.
  - out_vld = 0; out_* = 0 (storage cleared).
  - ptr = 0, count = 0.
- Latency: a packet accepted in cycle t is presented on out_* in cycle t+1 at the earliest.
- Throughput: one packet per cycle when out_rdy=1 continuously (steady state count=1).
- Full (count=2): no push in that cycle even if a pop happens. in_rdy is not gated by out_rdy, so there is no comb path from out_rdy to in_rdy. The next cycle count=1 and pushes resume.
- Empty: out_vld=0, and out_* show the last written or reset contents. Downstream must ignore them.
- Pointer wrap: ptr=N_IN−1 with grant N_IN−1 gives ptr=0.
- Reset mid-operation: buffered packets are dropped and out_vld=0 in the following cycle. Upstream packets not yet accepted stay pending. rst has priority over push and pop.

## Structure
- Shared bus package: ToyBus payload field widths (opcode 1, DATA_W, ID_W) and a packed ToyBus packet typedef. These are shared with the decoder nodes.
- One natural sub-module: `toy_bus_rr_arbiter` (N-way round-robin arbiter).
  - Inputs: req, ptr. Outputs: one-hot gnt, gnt_idx.
  - Pointer update stays in the node.

## Test plan
- Reset: assert rst 2 cycles with all in_vld=1. Require out_vld=0 and count=0. First grant after release goes to requester 0 (ptr=0).
- Fairness: N_IN=2, both in_vld held high, out_rdy=1. Require grants 0,1,0,1… Require out_data to alternate between in_data slices 0xAAAA_0000 and 0x5555_0000, one packet per cycle after the 1-cycle latency.
- Backpressure: out_rdy=0 with requester 0 streaming. Require exactly 2 packets accepted, then in_rdy=0. Set out_rdy=1. Require in-order drain, out_data=0x1, then 0x2, then 0x3.
- Full plus pop: count=2 and out_rdy=1 in one cycle. Require no in_rdy that cycle, count=1 after it, and accept resumes the next cycle.
- Wrap and skip: N_IN=4, ptr=3, only in_vld[1]=1. Require grant to 1 and ptr=2 afterwards. Packet src_id=0x6, tgt_id=0x1 must come out unchanged.
- Reset mid-stream: rst pulse with count=2. Require out_vld=0 next cycle and the pending in_vld[1] packet accepted after release.

Source files
------------

// File: rtl/toy_bus_rr_arb_node_pkg.sv
// ToyBus shared definitions: payload field widths, default packet layout, rr helper.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package toy_bus_rr_arb_node_pkg;

    localparam int OPCODE_W   = 1;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ID_W   = 4;
    localparam int FIFO_DEPTH = 2;

    // ToyBus packet at the default widths, shared with the decoder nodes.
    typedef struct packed {
        logic [OPCODE_W-1:0]   opcode;
        logic [DEF_DATA_W-1:0] data;
        logic [DEF_ID_W-1:0]   src_id;
        logic [DEF_ID_W-1:0]   tgt_id;
    } toy_pkt_t;

    // Round-robin successor of idx among n requesters, wrapping to 0.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/toy_bus_rr_arbiter.sv
// N-way round-robin arbiter: first request at or after ptr, scanned cyclically.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether a grant becomes a transfer.
module toy_bus_rr_arbiter #(
    parameter int N = 2,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] gnt_idx_o
);

    logic found;
    int   j;

    // Scan ptr, ptr+1, ... and grant the first requester found.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        j         = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!found && req_i[j]) begin
                found     = 1'b1;
                gnt_o[j]  = 1'b1;
                gnt_idx_o = PW'(j);
            end
        end
    end

endmodule

// File: rtl/toy_bus_rr_arb_node.sv
// Round-robin merge of N_IN ToyBus requesters into a 2-entry registered output buffer.
// Latency: 1 cycle from acceptance to out_vld; one packet per cycle sustained.
// Backpressure: in_rdy drops only when the buffer holds 2 entries; never combinationally from out_rdy.
module toy_bus_rr_arb_node
    import toy_bus_rr_arb_node_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ID_W   = DEF_ID_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_IN-1:0]      in_vld_i,
    output logic [N_IN-1:0]      in_rdy_o,
    input  logic [N_IN-1:0]      in_opcode_i,
    input  logic [N_IN*DATA_W-1:0] in_data_i,
    input  logic [N_IN*ID_W-1:0] in_src_id_i,
    input  logic [N_IN*ID_W-1:0] in_tgt_id_i,
    output logic                 out_vld_o,
    input  logic                 out_rdy_i,
    output logic                 out_opcode_o,
    output logic [DATA_W-1:0]    out_data_o,
    output logic [ID_W-1:0]      out_src_id_o,
    output logic [ID_W-1:0]      out_tgt_id_o
);

    localparam int PW = $clog2(N_IN);

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [DATA_W-1:0]   data;
        logic [ID_W-1:0]     src_id;
        logic [ID_W-1:0]     tgt_id;
    } pkt_t;

    logic [PW-1:0]   ptr_q, ptr_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [1:0]      count_q, count_d;
    pkt_t            mem_q [2];
    pkt_t            mem_d [2];

    logic [N_IN-1:0] gnt;
    logic [PW-1:0]   gnt_idx;
    logic            space_ok;
    logic            push;
    logic            pop;
    pkt_t            in_pkt;
    pkt_t            head;

    toy_bus_rr_arbiter #(
        .N (N_IN)
    ) u_arb (
        .req_i     (in_vld_i),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    // Handshake: ready follows the grant unless the buffer is full.
    always_comb begin
        space_ok = (count_q < 2'(FIFO_DEPTH));
        in_rdy_o = gnt & {N_IN{space_ok}};
        push     = |(in_vld_i & in_rdy_o);
        pop      = out_vld_o && out_rdy_i;
    end

    // Select the granted requester's payload.
    always_comb begin
        in_pkt.opcode = in_opcode_i[gnt_idx];
        in_pkt.data   = in_data_i[gnt_idx*DATA_W +: DATA_W];
        in_pkt.src_id = in_src_id_i[gnt_idx*ID_W +: ID_W];
        in_pkt.tgt_id = in_tgt_id_i[gnt_idx*ID_W +: ID_W];
    end

    // Next state: rr pointer advances past the winner only on an actual push.
    always_comb begin
        ptr_d    = ptr_q;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q;
        mem_d    = mem_q;
        if (push) begin
            ptr_d           = PW'(rr_next(int'(gnt_idx), N_IN));
            mem_d[wr_ptr_q] = in_pkt;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset drops buffered packets and clears storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            mem_q    <= '{default: '0};
        end else begin
            ptr_q    <= ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    // Present the buffer head.
    always_comb begin
        head         = mem_q[rd_ptr_q];
        out_vld_o    = (count_q != 2'd0);
        out_opcode_o = head.opcode;
        out_data_o   = head.data;
        out_src_id_o = head.src_id;
        out_tgt_id_o = head.tgt_id;
    end

endmodule

// File: tb/tb_toy_bus_rr_arb_node.sv
// Self-checking bench for toy_bus_rr_arb_node (N_IN=4): directed scenarios then random traffic.
// Expected packets queued at acceptance, checked by an independent output monitor.
// Model tracks rr pointer and occupancy as plain integers.
module tb_toy_bus_rr_arb_node;
    import toy_bus_rr_arb_node_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    in_vld;
    logic [N-1:0]    in_rdy;
    logic [N-1:0]    in_opcode;
    logic [N*DW-1:0] in_data;
    logic [N*IW-1:0] in_src_id;
    logic [N*IW-1:0] in_tgt_id;
    logic            out_vld;
    logic            out_rdy;
    logic            out_opcode;
    logic [DW-1:0]   out_data;
    logic [IW-1:0]   out_src_id;
    logic [IW-1:0]   out_tgt_id;

    toy_pkt_t pend [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign in_opcode[g]             = pend[g].opcode;
        assign in_data[g*DW +: DW]      = pend[g].data;
        assign in_src_id[g*IW +: IW]    = pend[g].src_id;
        assign in_tgt_id[g*IW +: IW]    = pend[g].tgt_id;
    end

    toy_bus_rr_arb_node #(
        .N_IN   (N),
        .DATA_W (DW),
        .ID_W   (IW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_vld_i     (in_vld),
        .in_rdy_o     (in_rdy),
        .in_opcode_i  (in_opcode),
        .in_data_i    (in_data),
        .in_src_id_i  (in_src_id),
        .in_tgt_id_i  (in_tgt_id),
        .out_vld_o    (out_vld),
        .out_rdy_i    (out_rdy),
        .out_opcode_o (out_opcode),
        .out_data_o   (out_data),
        .out_src_id_o (out_src_id),
        .out_tgt_id_o (out_tgt_id)
    );

    // Reference model state
    int         mptr;
    int         mcount;
    toy_pkt_t   exp_q [$];
    logic [N-1:0] acc;
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: check handshake outputs against the model, then advance the model.
    task automatic cycle();
        int gi;
        int j;
        logic [N-1:0] exp_rdy;
        bit do_pop;
        @(negedge clk);
        gi = -1;
        for (int k = 0; k < N; k++) begin
            j = (mptr + k) % N;
            if (gi < 0 && in_vld[j]) gi = j;
        end
        exp_rdy = (gi >= 0 && mcount < 2) ? (N'(1) << gi) : '0;
        check("in_rdy", 64'(in_rdy), 64'(exp_rdy));
        check("out_vld", 64'(out_vld), 64'(mcount > 0));
        do_pop = (mcount > 0) && out_rdy;
        acc = '0;
        @(posedge clk);
        #1;
        if (rst) begin
            mptr   = 0;
            mcount = 0;
            exp_q.delete();
        end else begin
            if (exp_rdy != '0) begin
                acc = exp_rdy;
                exp_q.push_back(pend[gi]);
                mptr = (gi + 1) % N;
                mcount++;
            end
            if (do_pop) mcount--;
        end
    endtask

    // Output monitor: every transfer must match the oldest accepted packet.
    initial begin
        toy_pkt_t e;
        forever begin
            @(negedge clk);
            if (out_vld === 1'b1 && out_rdy === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_out: got data %0h with nothing expected", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_opcode", 64'(out_opcode), 64'(e.opcode));
                    check("out_data", 64'(out_data), 64'(e.data));
                    check("out_src_id", 64'(out_src_id), 64'(e.src_id));
                    check("out_tgt_id", 64'(out_tgt_id), 64'(e.tgt_id));
                end
            end
        end
    end

    initial begin
        // Reset with every requester valid
        rst     = 1'b1;
        out_rdy = 1'b0;
        in_vld  = '1;
        for (int i = 0; i < N; i++) pend[i] = '{1'b1, 32'hDEAD_0000 + 32'(i), 4'(i), 4'hF};
        mptr    = 0;
        mcount  = 0;
        acc     = '0;
        @(posedge clk);
        #1;
        cycle();
        cycle();
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_opcode", 64'(out_opcode), 64'd0);
        check("rst_out_ids", 64'({out_src_id, out_tgt_id}), 64'd0);

        // Fairness: requesters 0 and 1 both always valid
        pend[0] = '{1'b0, 32'hAAAA_0000, 4'h0, 4'h2};
        pend[1] = '{1'b1, 32'h5555_0000, 4'h1, 4'h2};
        in_vld  = 4'b0011;
        rst     = 1'b0;
        out_rdy = 1'b1;
        repeat (8) cycle();

        // Backpressure: requester 0 streams 1,2,3 into a stalled output
        in_vld = '0;
        repeat (3) cycle();
        pend[0] = '{1'b0, 32'h1, 4'h3, 4'h4};
        in_vld  = 4'b0001;
        out_rdy = 1'b0;
        repeat (4) begin
            cycle();
            if (acc[0]) pend[0].data++;
        end
        out_rdy = 1'b1;
        repeat (6) begin
            cycle();
            if (acc[0]) begin
                if (pend[0].data == 32'h3) in_vld[0] = 1'b0;
                else pend[0].data++;
            end
        end

        // Wrap and skip: move pointer to 3, then only requester 1 requests
        in_vld = '0;
        repeat (3) cycle();
        pend[2] = '{1'b0, 32'h2222_2222, 4'h2, 4'h0};
        in_vld  = 4'b0100;
        cycle();
        pend[1] = '{1'b1, 32'h1234_5678, 4'h6, 4'h1};
        in_vld  = 4'b0010;
        cycle();
        pend[3] = '{1'b1, 32'h3333_3333, 4'h3, 4'h9};
        in_vld  = 4'b1100;
        cycle();
        in_vld[2] = 1'b0;
        cycle();
        in_vld = '0;
        repeat (3) cycle();

        // Reset mid-stream with a full buffer and requester 1 pending
        out_rdy = 1'b0;
        pend[0] = '{1'b0, 32'h100, 4'h0, 4'h5};
        in_vld  = 4'b0001;
        repeat (3) begin
            cycle();
            if (acc[0]) pend[0].data++;
        end
        pend[1] = '{1'b1, 32'h0BAD_F00D, 4'h1, 4'h7};
        in_vld  = 4'b0010;
        cycle();
        rst = 1'b1;
        cycle();
        rst     = 1'b0;
        out_rdy = 1'b1;
        repeat (4) begin
            cycle();
            if (acc[1]) in_vld[1] = 1'b0;
        end

        // Random traffic with occasional resets
        repeat (3000) begin
            rst     = ($urandom_range(0, 199) == 0);
            out_rdy = ($urandom_range(0, 3) != 0);
            cycle();
            for (int i = 0; i < N; i++) begin
                if (acc[i] || !in_vld[i]) begin
                    in_vld[i]      = ($urandom_range(0, 9) < 4);
                    pend[i].opcode = 1'($urandom);
                    pend[i].data   = $urandom;
                    pend[i].src_id = 4'($urandom);
                    pend[i].tgt_id = 4'($urandom);
                end
            end
        end

        // Drain
        rst     = 1'b0;
        in_vld  = '0;
        out_rdy = 1'b1;
        repeat (4) cycle();
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
